// File: rtl/aes_key_expand_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// aes_key_expand_seq
//   Iterative AES-128/192/256 key expansion. One 32-bit schedule word is
//   produced per non-stalled clock. Every group of four words is packed into
//   a 128-bit round key and pushed into a small output FIFO. Round keys leave
//   in order through a valid/ready handshake.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           begin a job (sampled only in IDLE)
//   key_len         00=128, 01=192, 10=256, 11=invalid
//   key             cipher key, MSB-aligned
//   abort           synchronous flush of the current job
//   rk_data         round key, word 4r at [127:96]
//   rk_round        round index of rk_data
//   rk_last         rk_data is the final round key
//   rk_valid        FIFO head valid
//   rk_ready        consumer accepts the head when rk_valid & rk_ready
//   busy            engine not idle
//   done            one-cycle pulse after the final round key handshake
//   err             one-cycle pulse after a start with an invalid key_len
// -----------------------------------------------------------------------------
module aes_key_expand_seq #(
    parameter int FIFO_DEPTH  = 2,
    parameter bit SUPPORT_192 = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    input  logic         abort,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
    output logic         rk_last,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXPAND = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = 128 + 4 + 1;

    // AES S-box, entry 0x00 in the top byte
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[(255 - int'(x)) * 8 +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // control state
    logic [1:0]       state;
    logic [5:0]       idx;       // schedule word counter i
    logic [2:0]       phase;     // i mod Nk
    logic [7:0]       rcon;
    logic [1:0]       klen;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // datapath state
    logic [255:0]     key_reg;
    logic [31:0]      win [8];   // win[7] = w[i-1]
    logic [95:0]      asm_reg;   // first three words of the current group
    logic [ENT_W-1:0] fifo_mem [2**PTR_W];

    logic [3:0]  nk_val;
    logic [3:0]  nr_val;
    logic        len_ok, start_ok, start_bad;
    logic        expanding, group_end, full, pop, stall, adv, push;
    logic        last_word, from_key;
    logic [31:0] prev, back, sub_in, sub_out, t_word, word;
    logic [ENT_W-1:0] head;

    always_comb begin
        case (klen)
            2'b01:   begin nk_val = 4'd6; nr_val = 4'd12; end
            2'b10:   begin nk_val = 4'd8; nr_val = 4'd14; end
            default: begin nk_val = 4'd4; nr_val = 4'd10; end
        endcase
    end

    assign len_ok    = (key_len == 2'b00) || (key_len == 2'b10) ||
                       (SUPPORT_192 && (key_len == 2'b01));
    assign start_ok  = (state == ST_IDLE) && start && len_ok && !abort;
    assign start_bad = (state == ST_IDLE) && start && !len_ok && !abort;

    assign rk_valid  = (count != '0);
    assign head      = fifo_mem[rd_ptr];
    assign rk_data   = rk_valid ? head[ENT_W-1:5] : '0;
    assign rk_round  = rk_valid ? head[4:1] : '0;
    assign rk_last   = rk_valid ? head[0] : 1'b0;
    assign busy      = (state != ST_IDLE);

    assign expanding = (state == ST_EXPAND);
    assign group_end = (idx[1:0] == 2'b11);
    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign pop       = rk_valid && rk_ready && !abort;
    // A full FIFO may still accept the group if the head leaves this cycle.
    assign stall     = expanding && group_end && full && !pop;
    assign adv       = expanding && !stall && !abort;
    assign push      = adv && group_end;
    assign last_word = (idx == {nr_val, 2'b11});
    assign from_key  = (idx < {2'b00, nk_val});

    // Next schedule word; a single SubWord serves both substitution cases.
    always_comb begin
        prev = win[7];
        case (klen)
            2'b01:   back = win[2];
            2'b10:   back = win[0];
            default: back = win[4];
        endcase
        sub_in  = (phase == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
        sub_out = sub_word(sub_in);
        if (phase == 3'd0)
            t_word = sub_out ^ {rcon, 24'h0};
        else if ((klen == 2'b10) && (phase == 3'd4))
            t_word = sub_out;
        else
            t_word = prev;
        word = from_key ? key_reg[255:224] : (back ^ t_word);
    end

    // control: FSM, counters, FIFO pointers, pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            idx    <= '0;
            phase  <= '0;
            rcon   <= 8'h01;
            klen   <= 2'b00;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= !abort && (state == ST_DRAIN) && pop && head[0];
            err  <= start_bad;
            if (abort) begin
                state  <= ST_IDLE;
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
                if (pop)
                    rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
                if (push && !pop)
                    count <= count + CNT_W'(1);
                else if (!push && pop)
                    count <= count - CNT_W'(1);

                case (state)
                    ST_IDLE: begin
                        if (start_ok) begin
                            state <= ST_EXPAND;
                            idx   <= '0;
                            phase <= '0;
                            rcon  <= 8'h01;
                            klen  <= key_len;
                        end
                    end
                    ST_EXPAND: begin
                        if (adv) begin
                            idx   <= idx + 6'd1;
                            phase <= ({1'b0, phase} == nk_val - 4'd1) ? 3'd0 : phase + 3'd1;
                            if (!from_key && (phase == 3'd0))
                                rcon <= xtime(rcon);
                            if (last_word)
                                state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (pop && head[0])
                            state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // datapath: key shift register, word window, group assembly, FIFO storage
    always_ff @(posedge clk) begin
        if (start_ok)
            key_reg <= key;
        else if (adv && from_key)
            key_reg <= {key_reg[223:0], 32'h0};
        if (adv) begin
            for (int k = 0; k < 7; k++)
                win[k] <= win[k+1];
            win[7]  <= word;
            asm_reg <= {asm_reg[63:0], word};
        end
        if (push)
            fifo_mem[wr_ptr] <= {asm_reg, word, idx[5:2], last_word};
    end

endmodule
